dmem_stream_reader: RTL
=======================

Name: dmem_stream_reader

Overview:
Read-side client for one port of the 1024x32 dual-port data memory. On a start command it fetches `length` words from `base_addr`, advancing by `stride` each word. It absorbs the memory's 1-cycle synchronous read latency and presents the words as a valid/ready stream to the DSP datapath, with full back-pressure support. The write controls of its port are held inactive.

Parameters:
ADDR_W, 10, memory word-address width (depth 2^ADDR_W)
DATA_W, 32, memory word width
LEN_W, 11, transfer-length width (0..1024 words)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only when busy=0
base_addr  input  ADDR_W  first word address, captured on accepted start
length  input  LEN_W  words to transfer, captured on accepted start
stride  input  ADDR_W  address increment per word, captured on accepted start
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer
mem_addr  output  ADDR_W  to memory port addr
mem_we  output  1  to memory port we; constant 0
mem_wdata  output  DATA_W  to memory port wdata; constant 0
mem_rdata  input  DATA_W  from memory port rdata; valid the cycle after the address is sampled
out_valid  output  1  stream data valid
out_data  output  DATA_W  stream word
out_last  output  1  marks final word of the transfer; qualified by out_valid
out_ready  input  1  stream sink ready

Behaviour:
- Reset values (async, immediate): busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0. Internal FIFO is emptied, in-flight flag and counters are cleared, and the FSM goes to IDLE.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1: capture the parameters.
  - length!=0: go to RUN, busy=1 next cycle.
  - length==0: done=1 next cycle for one cycle, busy stays 0, no reads issued, no stream output.
- start while busy=1 is ignored. Captured parameters stay fixed for the whole transfer.
- RUN, read issue:
  - A read is "issued" in a cycle when mem_addr carries the next address and the issue condition holds.
  - Issue condition: fifo_count + inflight < 2 + (out_valid & out_ready).
  - The word returned on mem_rdata the following cycle is written into a 2-entry FIFO.
- Addressing: the first read uses base_addr. Each subsequent read uses the previous address + stride, mod 2^ADDR_W (wraps 1023->0 silently).
- mem_addr holds its last value when no read is issued; unissued cycles never enqueue data.
- When all `length` reads have been issued, go to DRAIN.
- DRAIN: wait until the last word has been handshaken, then assert done for one cycle and return to IDLE. busy=0 in the same cycle as done.
- Stream rules:
  - out_data and out_last are driven from the FIFO head.
  - out_valid=1 whenever the FIFO is non-empty.
  - Once asserted, out_valid and out_data hold stable until out_ready=1.
  - out_last=1 only on word number length-1 (0-based).
- Latency: start sampled at edge E0. Read 0 is presented after E0. mem_rdata is valid after E1; the FIFO captures it at E2; out_valid=1 after E2.
- Throughput: with out_ready held 1, one word per cycle sustained. Total cycles from E0 to the done pulse = length+3.
- Back-pressure: with out_ready=0 at most 2 words are buffered and no read is issued, so no overflow and no data loss.
- Simultaneous FIFO push and pop in one cycle: count unchanged, order preserved.
- Reset mid-transfer: transfer is abandoned, nothing resumes after release, no done pulse.

Test Plan:
- Memory preloaded mem[k]=k+0x100; start base=4, len=4, stride=1, out_ready=1 -> out_data 0x104,0x105,0x106,0x107 on consecutive cycles; out_last on 0x107; out_valid rises 2 cycles after start edge; done pulses exactly once.
- Same transfer with out_ready toggling 1,0,0,1,0,1... -> identical data sequence, no duplicates or drops; out_data stable while stalled; mem_addr never advances more than 2 ahead of the consumed word.
- base=1022, len=4, stride=1 -> addresses 1022,1023,0,1; data 0x4FE,0x4FF,0x100,0x101.
- base=0, len=3, stride=256 -> addresses 0,256,512; len=0 -> done pulse next cycle, out_valid never rises, busy stays 0.
- Pulse start again mid-transfer with different base -> ignored; original transfer completes unchanged.
- Assert rst_n=0 after 2 words accepted on len=8 -> out_valid/busy drop immediately; after release, no output and no done until a new start.

Source files
------------

// File: rtl/dmem_stream_reader.sv
// Strided read client for one port of the dual-port data memory. It hides the
// 1-cycle read latency and presents the words as a valid/ready stream.
module dmem_stream_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [ADDR_W-1:0]        r_stride;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_issued;
  logic                     r_inflight;
  logic                     r_inflight_last;

  logic [1:0][DATA_W-1:0]   r_fifo_data;
  logic [1:0]               r_fifo_last;
  logic                     r_rd_ptr;
  logic                     r_wr_ptr;
  logic [1:0]               r_count;

  logic                     w_pop;
  logic                     w_push;
  logic                     w_issue;
  logic                     w_issue_last;
  logic [2:0]               w_occupancy;
  logic [2:0]               w_limit;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = out_valid & r_fifo_last[r_rd_ptr];

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight;

  // A read may only be issued if its word is guaranteed a FIFO slot when it
  // returns, counting the slot freed by a pop in this same cycle.
  assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_limit      = 3'd2 + {2'b00, w_pop};
  assign w_issue      = (r_state == RUN) && (w_occupancy < w_limit);
  assign w_issue_last = (r_issued == (r_len - LEN_W'(1)));

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_mem_addr      <= '0;
      r_stride        <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len    <= length;
            r_stride <= stride;
            r_issued <= '0;
            if (length != '0) begin
              r_state    <= RUN;
              r_busy     <= 1'b1;
              r_mem_addr <= base_addr;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_issued <= r_issued + LEN_W'(1);
            if (w_issue_last) begin
              r_state <= DRAIN;
            end else begin
              r_mem_addr <= r_mem_addr + r_stride;
            end
          end
        end
        DRAIN: begin
          // Every read is issued; finish once the last word has left the FIFO.
          if ((r_count == 2'd0) && !r_inflight) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the two FIFO entries are reset because out_data is read straight
  // from the head entry and must be zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data <= '0;
      r_fifo_last <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_rdata;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
